alu_req_issuer: RTL and testbench

//   Initiator-side front end for the combinational 8-bit ALU (a/b/op -> result/zero/overflow/carry).
//   - Accepts tagged operation requests over a valid/ready handshake.
//   - Drives the ALU ports from a registered issue stage and captures result+flags one cycle later.
//   - Returns in-order tagged responses through a response FIFO with backpressure.
//   - Keeps sticky overflow/carry status and an operation counter.

---
 rtl/alu_req_issuer_if.sv | 52 +++++
 rtl/alu_req_issuer.sv | 152 +++++++++++++++
 tb/tb_alu_req_issuer.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_req_issuer_if.sv
// Request / ALU / response signal bundle for alu_req_issuer.
// req_use_acc is present only when ALU_ACCUM_EN is defined.
interface alu_req_issuer_if #(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [2:0]       req_op;
    logic [TAG_W-1:0] req_tag;
`ifdef ALU_ACCUM_EN
    logic             req_use_acc;
`endif
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_op;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;
    logic             alu_overflow;
    logic             alu_carry;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic [2:0]       rsp_flags;
    logic [TAG_W-1:0] rsp_tag;

    modport master (
`ifdef ALU_ACCUM_EN
        output req_use_acc,
`endif
        output req_valid, req_a, req_b, req_op, req_tag,
        input  req_ready,
        input  alu_a, alu_b, alu_op,
        output alu_result, alu_zero, alu_overflow, alu_carry,
        input  rsp_valid, rsp_result, rsp_flags, rsp_tag,
        output rsp_ready
    );

    modport slave (
`ifdef ALU_ACCUM_EN
        input  req_use_acc,
`endif
        input  req_valid, req_a, req_b, req_op, req_tag,
        output req_ready,
        output alu_a, alu_b, alu_op,
        input  alu_result, alu_zero, alu_overflow, alu_carry,
        output rsp_valid, rsp_result, rsp_flags, rsp_tag,
        input  rsp_ready
    );
endinterface

// File: rtl/alu_req_issuer.sv
// Issue stage + credit-managed response FIFO in front of a combinational ALU.
// Optional macro ALU_ACCUM_EN adds an accumulator usable as operand A (req_use_acc).
module alu_req_issuer #(
    parameter int WIDTH     = 8,
    parameter int TAG_W     = 4,
    parameter int RSP_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    alu_req_issuer_if.slave bus,
    input  logic           clr_sticky_i,
    output logic           sticky_ovf_o,
    output logic           sticky_carry_o,
    output logic [15:0]    op_count_o
);
    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {IDLE, ISSUE} state_e;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic [2:0]       flags;
        logic [TAG_W-1:0] tag;
    } rsp_t;

    state_e           state_q, state_d;
    rsp_t             mem_q [RSP_DEPTH];
    rsp_t             last_q;
    rsp_t             wr_entry;
    rsp_t             head;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] a_q, b_q;
    logic [2:0]       op_q;
    logic [TAG_W-1:0] tag_q;
    logic             sticky_ovf_q, sticky_ovf_d;
    logic             sticky_carry_q, sticky_carry_d;
    logic [15:0]      op_count_q;
    logic             accept, push, pop, issue_busy, req_ready;
    logic [WIDTH-1:0] a_sel;

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = IDLE;
        if (accept) state_d = ISSUE;
    end

    // FSM: outputs; credit counts the in-flight issue as an occupied FIFO slot
    always_comb begin
        issue_busy = (state_q == ISSUE);
        push       = issue_busy;
        req_ready  = !rst &&
                     (({1'b0, count_q} + {{CNT_W{1'b0}}, issue_busy}) < (CNT_W+1)'(RSP_DEPTH));
    end

    assign accept = bus.req_valid & req_ready;
    assign pop    = bus.rsp_valid & bus.rsp_ready;

`ifdef ALU_ACCUM_EN
    logic [WIDTH-1:0] acc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       acc_q <= '0;
        else if (push) acc_q <= bus.alu_result;
    end

    // Back-to-back issue forwards the result being captured this cycle
    always_comb begin
        a_sel = bus.req_a;
        if (bus.req_use_acc) a_sel = issue_busy ? bus.alu_result : acc_q;
    end
`else
    always_comb a_sel = bus.req_a;
`endif

    always_comb begin
        wr_entry.result = bus.alu_result;
        wr_entry.flags  = {bus.alu_overflow, bus.alu_carry, bus.alu_zero};
        wr_entry.tag    = tag_q;

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        sticky_ovf_d   = (clr_sticky_i ? 1'b0 : sticky_ovf_q)   | (push & bus.alu_overflow);
        sticky_carry_d = (clr_sticky_i ? 1'b0 : sticky_carry_q) | (push & bus.alu_carry);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q            <= '0;
            b_q            <= '0;
            op_q           <= '0;
            tag_q          <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            last_q         <= '0;
            sticky_ovf_q   <= 1'b0;
            sticky_carry_q <= 1'b0;
            op_count_q     <= '0;
            for (int unsigned i = 0; i < RSP_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (accept) begin
                a_q   <= a_sel;
                b_q   <= bus.req_b;
                op_q  <= bus.req_op;
                tag_q <= bus.req_tag;
            end
            if (push) begin
                mem_q[wr_ptr_q] <= wr_entry;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
                op_count_q      <= op_count_q + 16'd1;
            end
            if (pop) begin
                last_q   <= mem_q[rd_ptr_q];
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q        <= count_d;
            sticky_ovf_q   <= sticky_ovf_d;
            sticky_carry_q <= sticky_carry_d;
        end
    end

    // Empty FIFO shows the most recently popped entry
    always_comb begin
        head = last_q;
        if (count_q != '0) head = mem_q[rd_ptr_q];
    end

    assign bus.req_ready  = req_ready;
    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
    assign bus.alu_op     = op_q;
    assign bus.rsp_valid  = (count_q != '0);
    assign bus.rsp_result = head.result;
    assign bus.rsp_flags  = head.flags;
    assign bus.rsp_tag    = head.tag;
    assign sticky_ovf_o   = sticky_ovf_q;
    assign sticky_carry_o = sticky_carry_q;
    assign op_count_o     = op_count_q;
endmodule

// File: tb/tb_alu_req_issuer.sv
// Self-checking bench for alu_req_issuer: directed table, corner sequences, random traffic.
module tb_alu_req_issuer;
    localparam int WIDTH = 8;
    localparam int TAG_W = 4;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr_sticky;
    logic        sticky_ovf, sticky_carry;
    logic [15:0] op_count;

    alu_req_issuer_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus();

    alu_req_issuer #(.WIDTH(WIDTH), .TAG_W(TAG_W), .RSP_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus.slave),
        .clr_sticky_i  (clr_sticky),
        .sticky_ovf_o  (sticky_ovf),
        .sticky_carry_o(sticky_carry),
        .op_count_o    (op_count)
    );

    always #5 clk = ~clk;

    // ALU: returns {ovf, carry, zero, result}
    function automatic logic [10:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] w;
        logic [7:0] r;
        logic       c, v;
        w = '0; r = '0; c = 1'b0; v = 1'b0;
        case (op)
            3'd0: begin w = {1'b0, a} + {1'b0, b}; r = w[7:0]; c = w[8]; v = (a[7] == b[7]) && (r[7] != a[7]); end
            3'd1: begin w = {1'b0, a} - {1'b0, b}; r = w[7:0]; c = w[8]; v = (a[7] != b[7]) && (r[7] != a[7]); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = ~a;
            3'd6: r = a << b[2:0];
            default: r = a >> b[2:0];
        endcase
        return {v, c, (r == 8'd0), r};
    endfunction

    logic [10:0] alu_out;
    always_comb begin
        alu_out          = alu_f(bus.alu_op, bus.alu_a, bus.alu_b);
        bus.alu_result   = alu_out[7:0];
        bus.alu_zero     = alu_out[8];
        bus.alu_carry    = alu_out[9];
        bus.alu_overflow = alu_out[10];
    end

    typedef struct {
        logic [7:0] res;
        logic [2:0] flags;
        logic [3:0] tag;
    } rsp_t;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] tag;
        logic [7:0] exp_res;
        logic [2:0] exp_flags;
    } vec_t;

    // Reference model: outstanding = accepted but not yet popped
    rsp_t        exp_q[$];
    int          outst;
    bit          pend_v;
    logic [2:0]  pend_flags;
    int unsigned cap_cnt;
    bit          m_sov, m_scy;
    logic [7:0]  m_last_res;
    bit          last_acc, last_pop;
    logic [7:0]  last_pop_res;
    logic [3:0]  last_pop_tag;
    int          n_chk, n_fail;
    vec_t        vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        outst      = 0;
        pend_v     = 1'b0;
        pend_flags = '0;
        cap_cnt    = 0;
        m_sov      = 1'b0;
        m_scy      = 1'b0;
        m_last_res = '0;
    endtask

    task automatic cycle(input bit v, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] tag, input bit use_acc, input bit rr, input bit clr);
        rsp_t        e;
        logic [10:0] ao;
        logic [7:0]  aa;
        @(negedge clk);
        bus.req_valid = v;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_tag   = tag;
        bus.rsp_ready = rr;
        clr_sticky    = clr;
`ifdef ALU_ACCUM_EN
        bus.req_use_acc = use_acc;
`endif
        #1;
        chk("req_ready", bus.req_ready, outst < DEPTH);
        chk("rsp_valid", bus.rsp_valid, (outst - int'(pend_v)) > 0);
        chk("op_count", op_count, cap_cnt[15:0]);
        chk("sticky_ovf", sticky_ovf, m_sov);
        chk("sticky_carry", sticky_carry, m_scy);
        last_acc = v && bus.req_ready;
        last_pop = bus.rsp_valid && rr;
        if (last_pop) begin
            last_pop_res = bus.rsp_result;
            last_pop_tag = bus.rsp_tag;
            if (exp_q.size() == 0) chk("rsp_unexpected", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk("rsp_result", bus.rsp_result, e.res);
                chk("rsp_flags", bus.rsp_flags, e.flags);
                chk("rsp_tag", bus.rsp_tag, e.tag);
            end
        end
        if (clr) begin m_sov = 1'b0; m_scy = 1'b0; end
        if (pend_v) begin
            cap_cnt++;
            m_sov = m_sov | pend_flags[2];
            m_scy = m_scy | pend_flags[1];
        end
        pend_v = last_acc;
        if (last_acc) begin
            aa = a;
`ifdef ALU_ACCUM_EN
            if (use_acc) aa = m_last_res;
`endif
            ao         = alu_f(op, aa, b);
            m_last_res = ao[7:0];
            pend_flags = ao[10:8];
            e.res      = ao[7:0];
            e.flags    = ao[10:8];
            e.tag      = tag;
            exp_q.push_back(e);
        end
        outst += int'(last_acc) - int'(last_pop);
    endtask

    task automatic idle(input bit rr);
        cycle(1'b0, 3'd0, 8'd0, 8'd0, 4'd0, 1'b0, rr, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        clr_sticky    = 1'b0;
        #1;
        model_reset();
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_op_count", op_count, 0);
        chk("rst_sticky_ovf", sticky_ovf, 0);
        chk("rst_sticky_carry", sticky_carry, 0);
        chk("rst_req_ready", bus.req_ready, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int acc_n;
        n_chk = 0; n_fail = 0;
        rst = 1'b0; clr_sticky = 1'b0;
        bus.req_valid = 1'b0; bus.req_a = '0; bus.req_b = '0; bus.req_op = '0; bus.req_tag = '0;
        bus.rsp_ready = 1'b0;
`ifdef ALU_ACCUM_EN
        bus.req_use_acc = 1'b0;
`endif
        model_reset();
        #2 rst = 1'b1;
        #1;
        chk("reset_req_ready", bus.req_ready, 0);
        chk("reset_rsp_valid", bus.rsp_valid, 0);
        chk("reset_alu_a", bus.alu_a, 0);
        chk("reset_alu_b", bus.alu_b, 0);
        chk("reset_alu_op", bus.alu_op, 0);
        chk("reset_rsp_result", bus.rsp_result, 0);
        chk("reset_rsp_flags", bus.rsp_flags, 0);
        chk("reset_rsp_tag", bus.rsp_tag, 0);
        chk("reset_op_count", op_count, 0);
        chk("reset_sticky", {sticky_ovf, sticky_carry}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // {op, a, b, tag, result, {ovf,carry,zero}}
        vecs[0] = '{3'd0, 8'h7F, 8'h01, 4'd3, 8'h80, 3'b100};
        vecs[1] = '{3'd1, 8'h00, 8'h01, 4'd4, 8'hFF, 3'b010};
        vecs[2] = '{3'd4, 8'h5A, 8'h5A, 4'd5, 8'h00, 3'b001};
        vecs[3] = '{3'd0, 8'hFF, 8'h01, 4'd6, 8'h00, 3'b011};
        vecs[4] = '{3'd2, 8'hF0, 8'h3C, 4'd7, 8'h30, 3'b000};
        vecs[5] = '{3'd3, 8'h0F, 8'hF0, 4'd8, 8'hFF, 3'b000};
        vecs[6] = '{3'd5, 8'h55, 8'h00, 4'd9, 8'hAA, 3'b000};
        vecs[7] = '{3'd7, 8'h80, 8'h03, 4'hA, 8'h10, 3'b000};
        vecs[8] = '{3'd1, 8'h80, 8'h01, 4'hB, 8'h7F, 3'b100};
        vecs[9] = '{3'd6, 8'h81, 8'h01, 4'hC, 8'h02, 3'b000};

        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, 1'b0, 1'b0, 1'b0);
            idle(1'b0);
            idle(1'b1);
            chk($sformatf("vec%0d_valid", i), bus.rsp_valid, 1);
            chk($sformatf("vec%0d_result", i), bus.rsp_result, vecs[i].exp_res);
            chk($sformatf("vec%0d_flags", i), bus.rsp_flags, vecs[i].exp_flags);
            chk($sformatf("vec%0d_tag", i), bus.rsp_tag, vecs[i].tag);
            idle(1'b0);
            chk($sformatf("vec%0d_hold_result", i), bus.rsp_result, vecs[i].exp_res);
            chk($sformatf("vec%0d_hold_alu_a", i), bus.alu_a, vecs[i].a);
            chk($sformatf("vec%0d_op_count", i), op_count, i + 1);
            if (i == 0) chk("t1_sticky_ovf", sticky_ovf, 1);
        end

        // Backpressure: only DEPTH requests fit while the consumer stalls
        acc_n = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 3'd2, 8'hFF, 8'(i), 4'(i), 1'b0, 1'b0, 1'b0);
            if (last_acc) acc_n++;
        end
        chk("bp_accepted", acc_n, 4);
        chk("bp_ready_low", bus.req_ready, 0);
        idle(1'b1);
        chk("bp_pop_tag0", last_pop_tag, 0);
        chk("bp_ready_at_pop", bus.req_ready, 0);
        idle(1'b0);
        chk("bp_ready_after_pop", bus.req_ready, 1);
        for (int k = 1; k < 4; k++) begin
            idle(1'b1);
            chk($sformatf("bp_pop_tag%0d", k), last_pop_tag, k);
        end

        // Streaming: one response per cycle without bubbles
        for (int i = 0; i < 10; i++) begin
            cycle(i < 8, 3'd6, 8'h01, 8'(i), 4'(i), 1'b0, 1'b1, 1'b0);
            if (i >= 2) begin
                chk("stream_valid", last_pop, 1);
                chk("stream_result", last_pop_res, 8'h01 << (i - 2));
            end
        end

        // Reset with three queued responses and one in issue
        cycle(1'b1, 3'd0, 8'h7F, 8'h01, 4'hA, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 3'd0, 8'hFF, 8'h01, 4'hB, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 3'd3, 8'h12, 8'h34, 4'hC, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 3'd4, 8'h0F, 8'h01, 4'hD, 1'b0, 1'b0, 1'b0);
        do_reset();
        for (int i = 0; i < 5; i++) begin
            idle(1'b1);
            chk("post_rst_no_rsp", bus.rsp_valid, 0);
        end

`ifdef ALU_ACCUM_EN
        cycle(1'b1, 3'd0, 8'h05, 8'h00, 4'd1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 3'd0, 8'hEE, 8'h03, 4'd2, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        chk("acc_first", last_pop_res, 8'h05);
        idle(1'b1);
        chk("acc_forward", last_pop_res, 8'h08);
        cycle(1'b0, 3'd0, 8'd0, 8'd0, 4'd0, 1'b0, 1'b1, 1'b1);
        idle(1'b1);
        chk("clr_sticky", sticky_ovf, 0);
        cycle(1'b1, 3'd0, 8'h7F, 8'h01, 4'd3, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 3'd0, 8'd0, 8'd0, 4'd0, 1'b0, 1'b1, 1'b1);
        idle(1'b1);
        chk("set_beats_clr", sticky_ovf, 1);
`endif

        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
                  4'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 9) < 6,
                  $urandom_range(0, 19) == 0);
        end
        for (int i = 0; i < 20 && outst > 0; i++) idle(1'b1);
        idle(1'b1);
        chk("drain_empty", bus.rsp_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
